// File: rtl/mic_pkg.sv
// Shared widths, PCM word type, shift-and-clamp helper and parameter legality
// check for the CIC microphone decimator.
package mic_pkg;

  // Upper bound on the internal accumulator width handled by sat_shift.
  localparam int MAX_W    = 64;
  localparam int PCM_BITS = 16;

  typedef logic signed [PCM_BITS-1:0] pcm_t;

  // CIC bit growth: K bits cover the full DC gain pDecim**pOrder.
  function automatic int cic_k(input int order, input int decim);
    return order * $clog2(decim);
  endfunction

  // One extra bit so the comb result range [0, 2^K] fits unsigned.
  function automatic int cic_w(input int order, input int decim);
    return cic_k(order, decim) + 1;
  endfunction

  function automatic bit params_ok(input int order, input int decim, input int abits);
    int k;
    k = cic_k(order, decim);
    return (order >= 1) && (order <= 5) &&
           (decim >= 4) && ((decim & (decim - 1)) == 0) &&
           (abits >= 1) && (abits <= k) && (k + 1 <= MAX_W);
  endfunction

  // Arithmetic right shift followed by a clamp into a signed abits-wide range.
  function automatic longint sat_shift(input longint s, input int shift, input int abits);
    longint t;
    longint hi;
    longint lo;
    t  = s >>> shift;
    hi = (longint'(1) <<< (abits - 1)) - 1;
    lo = -(longint'(1) <<< (abits - 1));
    if (t > hi)      return hi;
    else if (t < lo) return lo;
    return t;
  endfunction

endpackage

// File: rtl/mic_cic_decimator.sv
// Order-pOrder CIC decimator turning a 1-bit PDM stream into signed PCM with a
// valid/ready output. Optional settling blanking via MIC_CIC_WARMUP_EN.
module mic_cic_decimator
  import mic_pkg::*;
#(
  parameter int pOrder     = 3,
  parameter int pDecim     = 64,
  parameter int pAudioBits = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         pdm_stb,
  input  logic                         pdm_bit,
  output logic signed [pAudioBits-1:0] pcm_data,
  output logic                         pcm_valid,
  input  logic                         pcm_ready,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int LOG_D = $clog2(pDecim);
  localparam int K     = cic_k(pOrder, pDecim);
  localparam int W     = cic_w(pOrder, pDecim);
  localparam int SHIFT = K - pAudioBits;

  // Mid-scale offset 2^(K-1), built as W bits: 2'b01 followed by K-1 zeros.
  localparam logic [W-1:0]     HALF     = {2'b01, {(K-1){1'b0}}};
  localparam logic [LOG_D-1:0] CNT_LAST = '1;

  typedef logic signed [pAudioBits-1:0] pcm_word_t;

  if (!params_ok(pOrder, pDecim, pAudioBits)) begin : g_param_check
    $error("mic_cic_decimator: illegal pOrder/pDecim/pAudioBits combination");
  end

  logic [W-1:0]       integ  [pOrder];
  logic [W-1:0]       comb_x [pOrder+1];
  logic [LOG_D-1:0]   cnt;
  logic               dec_tick;
  logic               sample_tick;
  logic [W-1:0]       y;
  logic signed [W-1:0] s_val;
  pcm_word_t          pcm_next;

  // ---------------------------------------------------------------------------
  // Integrator chain: each stage consumes the previous stage's registered value,
  // so the chain is pipelined and every stage updates on the same strobe edge.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < pOrder; i++) begin : g_integ
    logic [W-1:0] acc;
    logic [W-1:0] addend;

    if (i == 0) begin : g_first
      assign addend = {{(W-1){1'b0}}, pdm_bit};
    end else begin : g_next
      assign addend = integ[i-1];
    end

    // NOTE: sequential state uses non-blocking assignment so every stage sees
    // its neighbour's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc <= '0;
      else if (!en)     acc <= '0;
      else if (pdm_stb) acc <= acc + addend;
    end

    assign integ[i] = acc;
  end

  // Decimation counter; the tick is registered, so it lands one cycle after the
  // window's final strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dec_tick <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      dec_tick <= 1'b0;
    end else begin
      dec_tick <= pdm_stb && (cnt == CNT_LAST);
      if (pdm_stb) cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Comb chain: combinational differences, delays captured on dec_tick.
  // ---------------------------------------------------------------------------
  assign comb_x[0] = integ[pOrder-1];

  for (genvar i = 0; i < pOrder; i++) begin : g_comb
    logic [W-1:0] dly;

    assign comb_x[i+1] = comb_x[i] - dly;

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset like
    // any other register; that guarantees the first window after reset/enable
    // starts from a clean comb state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        dly <= '0;
      else if (!en)      dly <= '0;
      else if (dec_tick) dly <= comb_x[i];
    end
  end

  assign y = comb_x[pOrder];

  // NOTE: every variable below is assigned on every pass, so no latch can form.
  always_comb begin
    s_val    = signed'(y - HALF);
    pcm_next = pcm_word_t'(sat_shift(longint'(s_val), SHIFT, pAudioBits));
  end

`ifdef MIC_CIC_WARMUP_EN
  // Blank the first pOrder comb outputs while the filter history fills up.
  localparam int                   WARM_BITS = $clog2(pOrder + 1);
  localparam logic [WARM_BITS-1:0] WARM_LAST = WARM_BITS'(pOrder);

  logic [WARM_BITS-1:0] warm_cnt;
  logic                 warm_done;

  assign warm_done = (warm_cnt == WARM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      warm_cnt <= '0;
    else if (!en)                    warm_cnt <= '0;
    else if (dec_tick && !warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  assign sample_tick = dec_tick && warm_done;
`else
  assign sample_tick = dec_tick;
`endif

  // ---------------------------------------------------------------------------
  // Output register with valid/ready handshake and sticky overrun.
  // A new sample may replace the held one only when that one leaves this cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (!en) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_tick && (!pcm_valid || pcm_ready)) begin
        pcm_data  <= pcm_next;
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end

      if (sample_tick && pcm_valid && !pcm_ready) overrun <= 1'b1;
      else if (overrun_clr)                       overrun <= 1'b0;
    end
  end

endmodule
